// File: rtl/maxpool3d_pkg.sv
// Shared types and helpers for the 3D max-pool window sequencer.
package maxpool3d_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned MAX_W = 64;

    typedef logic signed [MAX_W-1:0] wide_t;

    function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned k,
                                            input int unsigned s);
        return (in_dim - k) / s + 1;
    endfunction

    function automatic wide_t smax(input wide_t a, input wide_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool3d_window_sequencer_addr_gen.sv
// Kernel offset counters (kw innermost) and feature-memory address for the current window.
module maxpool3d_addr_gen
    import maxpool3d_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IN_H   = 4,
    parameter int unsigned IN_W   = 4,
    parameter int unsigned K      = 2,
    parameter int unsigned S      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [CNT_W-1:0]  od,
    input  logic [CNT_W-1:0]  oh,
    input  logic [CNT_W-1:0]  ow,
    input  logic [ADDR_W-1:0] base,
    output logic              last_c,
    output logic [ADDR_W-1:0] addr_c
);

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K - 1);

    logic [CNT_W-1:0] kd, kh, kw;
    logic             kd_last, kh_last, kw_last;
    logic [31:0]      d, h, w, lin;

    assign kd_last = (kd == K_LAST);
    assign kh_last = (kh == K_LAST);
    assign kw_last = (kw == K_LAST);
    assign last_c  = kd_last && kh_last && kw_last;

    // Counters wrap to zero after the last offset so the next window starts clean.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            kd <= '0;
            kh <= '0;
            kw <= '0;
        end else if (advance) begin
            if (kw_last) begin
                kw <= '0;
                if (kh_last) begin
                    kh <= '0;
                    kd <= kd_last ? '0 : kd + CNT_W'(1);
                end else begin
                    kh <= kh + CNT_W'(1);
                end
            end else begin
                kw <= kw + CNT_W'(1);
            end
        end
    end

    always_comb begin
        d      = 32'(od) * 32'(S) + 32'(kd);
        h      = 32'(oh) * 32'(S) + 32'(kh);
        w      = 32'(ow) * 32'(S) + 32'(kw);
        lin    = (d * 32'(IN_H) + h) * 32'(IN_W) + w;
        addr_c = base + ADDR_W'(lin);
    end

endmodule

// File: rtl/maxpool3d_window_sequencer.sv
// Walks every output voxel, issues its K^3 window reads and folds the responses through a signed max.
module maxpool3d_window_sequencer
    import maxpool3d_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IN_D   = 4,
    parameter int unsigned IN_H   = 4,
    parameter int unsigned IN_W   = 4,
    parameter int unsigned K      = 2,
    parameter int unsigned S      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    input  logic [DATA_W-1:0] rd_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index
);

    if (K < 1 || K > IN_D || K > IN_H || K > IN_W || S < 1) begin : g_param_check
        $error("maxpool3d_window_sequencer: K must be 1..min(IN_D,IN_H,IN_W) and S >= 1");
    end

    localparam int unsigned OD   = out_dim(IN_D, K, S);
    localparam int unsigned OH   = out_dim(IN_H, K, S);
    localparam int unsigned OW   = out_dim(IN_W, K, S);
    localparam int unsigned K3   = K * K * K;
    localparam int unsigned RC_W = $clog2(K3 + 1);

    localparam logic [CNT_W-1:0] OD_LAST  = CNT_W'(OD - 1);
    localparam logic [CNT_W-1:0] OH_LAST  = CNT_W'(OH - 1);
    localparam logic [CNT_W-1:0] OW_LAST  = CNT_W'(OW - 1);
    localparam logic [RC_W-1:0]  RSP_LAST = RC_W'(K3 - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  od, oh, ow;
    logic [ADDR_W-1:0] out_idx;
    logic [RC_W-1:0]   rsp_cnt;
    logic [DATA_W-1:0] acc, acc_max;
    logic              req_fire, rsp_fire, out_fire;
    logic              req_last_c, rsp_last, win_last;

    assign req_fire = rd_req_valid && rd_req_ready;
    assign rsp_fire = rd_rsp_valid && (state != ST_IDLE);
    assign out_fire = out_valid && out_ready;
    assign rsp_last = rsp_fire && (rsp_cnt == RSP_LAST);
    assign win_last = (od == OD_LAST) && (oh == OH_LAST) && (ow == OW_LAST);

    maxpool3d_addr_gen #(
        .ADDR_W (ADDR_W),
        .IN_H   (IN_H),
        .IN_W   (IN_W),
        .K      (K),
        .S      (S)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .advance (req_fire),
        .od      (od),
        .oh      (oh),
        .ow      (ow),
        .base    (base_q),
        .last_c  (req_last_c),
        .addr_c  (rd_req_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_ISSUE;
            ST_ISSUE: if (req_fire && req_last_c) state_next = ST_WAIT;
            ST_WAIT:  if (rsp_last) state_next = ST_EMIT;
            ST_EMIT:  if (out_fire) state_next = win_last ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        rd_req_valid = 1'b0;
        out_valid    = 1'b0;
        case (state)
            ST_ISSUE: begin busy = 1'b1; rd_req_valid = 1'b1; end
            ST_WAIT:  busy = 1'b1;
            ST_EMIT:  begin busy = 1'b1; out_valid = 1'b1; end
            ST_DONE:  begin busy = 1'b1; done = 1'b1; end
            default:  ;
        endcase
    end

    assign acc_max = DATA_W'(smax(MAX_W'(signed'(acc)), MAX_W'(signed'(rd_rsp_data))));

    // First response of a window seeds the accumulator so all-negative windows work.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            rsp_cnt <= '0;
            acc     <= '0;
        end else begin
            if (state == ST_IDLE && start) base_q <= base_addr;
            if (state == ST_IDLE || out_fire) rsp_cnt <= '0;
            else if (rsp_fire)                rsp_cnt <= rsp_cnt + RC_W'(1);
            if (rsp_fire) acc <= (rsp_cnt == '0) ? rd_rsp_data : acc_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            od      <= '0;
            oh      <= '0;
            ow      <= '0;
            out_idx <= '0;
        end else if (out_fire) begin
            out_idx <= win_last ? '0 : out_idx + ADDR_W'(1);
            if (ow == OW_LAST) begin
                ow <= '0;
                if (oh == OH_LAST) begin
                    oh <= '0;
                    od <= (od == OD_LAST) ? '0 : od + CNT_W'(1);
                end else begin
                    oh <= oh + CNT_W'(1);
                end
            end else begin
                ow <= ow + CNT_W'(1);
            end
        end
    end

    assign out_data  = acc;
    assign out_index = out_idx;

endmodule

// File: tb/tb_maxpool3d_window_sequencer.sv
// Randomized bench for the max-pool window sequencer against a loop-based pooling model.
`timescale 1ns/1ps
module tb_maxpool3d_window_sequencer;

    localparam int P_IN = 4;
    localparam int P_K  = 2;
    localparam int P_S  = 2;
    localparam int P_O  = 2;
    localparam int N_RD = 64;
    localparam int N_OUT = 8;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start3;
    logic [15:0] base_addr;
    logic        busy, done, rd_req_valid, rd_req_ready, rd_rsp_valid, out_valid, out_ready;
    logic [15:0] rd_req_addr, out_index;
    logic [31:0] rd_rsp_data, out_data;
    logic        busy3, done3, rd_req_valid3, rd_req_ready3, rd_rsp_valid3, out_valid3, out_ready3;
    logic [15:0] rd_req_addr3, out_index3;
    logic [31:0] rd_rsp_data3, out_data3;

    assign rd_req_ready3 = 1'b1;
    assign out_ready3    = 1'b1;

    maxpool3d_window_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy), .done(done),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_index(out_index)
    );

    maxpool3d_window_sequencer #(.IN_D(3), .IN_H(3), .IN_W(3), .K(3), .S(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .base_addr(16'h0000), .busy(busy3), .done(done3),
        .rd_req_valid(rd_req_valid3), .rd_req_ready(rd_req_ready3), .rd_req_addr(rd_req_addr3),
        .rd_rsp_valid(rd_rsp_valid3), .rd_rsp_data(rd_rsp_data3), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_data(out_data3), .out_index(out_index3)
    );

    // Run configuration and reference model (written by the stimulus process only).
    int          mode, lat, rdy_mode, ordy_mode;
    logic [15:0] cur_base;
    logic [31:0] rnd_tab [64];
    logic [15:0] exp_addr [N_RD];
    logic [31:0] exp_data [N_OUT];
    logic [15:0] exp_idx [N_OUT];
    logic [31:0] lit [N_OUT] = '{32'd21, 32'd23, 32'd29, 32'd31, 32'd53, 32'd55, 32'd61, 32'd63};

    // Checker/responder state (written by the negedge process only).
    int   n_cmp = 0, n_bad = 0;
    int   ncyc = 0, ap = 0, op = 0, run_reads = 0, run_dones = 0, run_stalls = 0, held = 0;
    int   tot_reads = 0, tot_dones = 0, reads3 = 0, outs3 = 0, dones3 = 0;
    bit   rst_seen = 1'b0, prev_done = 1'b0, pin = 1'b0, pend3 = 1'b0;
    logic [15:0] pend_addr3;
    rsp_t mq [$];

    function automatic logic [31:0] memval(input logic [15:0] a);
        logic [15:0] off;
        off = a - cur_base;
        case (mode)
            0:       return 32'(a);
            1:       return 32'hFFFF_FFFB;
            default: return rnd_tab[off[5:0]];
        endcase
    endfunction

    function automatic logic [31:0] memval3(input logic [15:0] a);
        return (a == 16'd13) ? 32'h7FFF_FFFF : 32'h8000_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Direct pooling over the input cube: window order ow-inner, read order kw-inner.
    task automatic build_model();
        int               k, lin, oi;
        logic [15:0]      a;
        logic signed [31:0] v, m;
        k = 0;
        for (int od = 0; od < P_O; od++)
            for (int oh = 0; oh < P_O; oh++)
                for (int ow = 0; ow < P_O; ow++) begin
                    m = 0;
                    for (int kd = 0; kd < P_K; kd++)
                        for (int kh = 0; kh < P_K; kh++)
                            for (int kw = 0; kw < P_K; kw++) begin
                                lin = ((od * P_S + kd) * P_IN + oh * P_S + kh) * P_IN + ow * P_S + kw;
                                a   = cur_base + 16'(lin);
                                v   = signed'(memval(a));
                                exp_addr[k] = a;
                                if (kd == 0 && kh == 0 && kw == 0) m = v;
                                else if (v > m) m = v;
                                k++;
                            end
                    oi = (od * P_O + oh) * P_O + ow;
                    exp_data[oi] = m;
                    exp_idx[oi]  = 16'(oi);
                end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (mq.size() > 0 && mq[0].due <= ncyc) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = mq[0].data;
            void'(mq.pop_front());
        end else begin
            rd_rsp_valid = 1'b0;
            rd_rsp_data  = $urandom;
        end
        rd_rsp_valid3 = pend3;
        rd_rsp_data3  = pend3 ? memval3(pend_addr3) : $urandom;
        pend3         = rd_req_valid3 && !rst;
        pend_addr3    = rd_req_addr3;

        if (!rst && start && !busy) begin
            ap = 0; op = 0; run_reads = 0; run_dones = 0; run_stalls = 0; held = 0;
            pin = (mode == 0) && (cur_base == 16'h0000);
            if (pin) begin
                for (int i = 0; i < N_OUT; i++) check("model_vs_literal", 64'(exp_data[i]), 64'(lit[i]));
                check("model_addr1", 64'(exp_addr[1]), 64'd1);
                check("model_addr2", 64'(exp_addr[2]), 64'd4);
                check("model_addr63", 64'(exp_addr[63]), 64'd63);
            end
        end

        case (rdy_mode)
            0:       rd_req_ready = 1'b1;
            1:       rd_req_ready = (ncyc % 3 == 0);
            default: rd_req_ready = 1'($urandom_range(0, 1));
        endcase
        case (ordy_mode)
            0: out_ready = 1'b1;
            1: begin
                if (out_valid && held < 10) begin out_ready = 1'b0; held++; end
                else out_ready = 1'b1;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase

        if (rd_req_valid && rd_req_ready) begin
            mq.push_back('{ncyc + lat, memval(rd_req_addr)});
            tot_reads++;
        end

        if (rst) begin
            rst_seen  = 1'b1;
            prev_done = 1'b0;
        end else begin
            if (rst_seen) begin
                rst_seen = 1'b0;
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                check("rst_rd_req_valid", 64'(rd_req_valid), 64'd0);
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_rd_req_addr", 64'(rd_req_addr), 64'd0);
                check("rst_out_data", 64'(out_data), 64'd0);
                check("rst_out_index", 64'(out_index), 64'd0);
            end
            if (rd_req_valid && rd_req_ready) begin
                if (ap < N_RD) check("rd_addr", 64'(rd_req_addr), 64'(exp_addr[ap]));
                else check("rd_extra_request", 64'(ap), 64'(N_RD - 1));
                ap++;
                run_reads++;
            end
            if (out_valid) begin
                check("no_read_in_emit", 64'(rd_req_valid), 64'd0);
                if (op < N_OUT) begin
                    check("out_data", 64'(out_data), 64'(exp_data[op]));
                    check("out_index", 64'(out_index), 64'(exp_idx[op]));
                    if (pin) check("out_data_literal", 64'(out_data), 64'(lit[op]));
                end else begin
                    check("out_extra", 64'(op), 64'(N_OUT - 1));
                end
                if (out_ready) op++;
                else run_stalls++;
            end
            if (prev_done) check("busy_after_done", 64'(busy), 64'd0);
            prev_done = done;
            if (done) begin
                check("busy_in_done", 64'(busy), 64'd1);
                check("done_reads", 64'(run_reads), 64'(N_RD));
                check("done_outputs", 64'(op), 64'(N_OUT));
                check("done_once", 64'(run_dones), 64'd0);
                if (ordy_mode == 1) check("stall_cycles", 64'(run_stalls), 64'd10);
                run_dones++;
                tot_dones++;
            end
            if (rd_req_valid3) reads3++;
            if (out_valid3) begin
                check("k3_out_data", 64'(out_data3), 64'h7FFF_FFFF);
                check("k3_out_index", 64'(out_index3), 64'd0);
                outs3++;
            end
            if (done3) begin
                check("k3_reads", 64'(reads3), 64'd27);
                check("k3_outputs", 64'(outs3), 64'd1);
                dones3++;
            end
        end
    end

    task automatic pulse_start(input logic [15:0] b);
        @(posedge clk); #1 start = 1'b1; base_addr = b;
        @(posedge clk); #1 start = 1'b0; base_addr = 16'($urandom);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            if (tot_dones > d0) return;
        end
        $display("FAIL run_timeout: no done within 4000 cycles");
        $fatal(1, "run did not complete");
    endtask

    task automatic run_one(input int m, input int l, input int rm, input int om,
                           input logic [15:0] b, input bit extra_start);
        int d0;
        mode = m; lat = l; rdy_mode = rm; ordy_mode = om; cur_base = b;
        build_model();
        d0 = tot_dones;
        pulse_start(b);
        if (extra_start) begin
            repeat (6) @(posedge clk);
            #1 start = 1'b1; base_addr = 16'h1234;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_done(d0);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int r0, d3;
        rst = 1'b1; start = 1'b0; start3 = 1'b0; base_addr = 16'h0000;
        mode = 0; lat = 2; rdy_mode = 0; ordy_mode = 0; cur_base = 16'h0000;
        foreach (rnd_tab[i]) rnd_tab[i] = $urandom;
        build_model();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        run_one(0, 2, 0, 0, 16'h0000, 1'b0);
        run_one(1, 2, 0, 0, 16'h0040, 1'b0);
        run_one(0, 2, 0, 1, 16'h0000, 1'b0);
        run_one(0, 5, 1, 0, 16'h0000, 1'b0);
        run_one(0, 2, 0, 0, 16'h0000, 1'b1);

        // Abort a run mid-flight, let stale responses drain into IDLE, then rerun.
        mode = 0; lat = 2; rdy_mode = 0; ordy_mode = 0; cur_base = 16'h0000;
        build_model();
        r0 = tot_reads;
        pulse_start(16'h0000);
        for (int i = 0; i < 2000 && (tot_reads - r0) < 20; i++) @(posedge clk);
        if ((tot_reads - r0) < 20) begin
            $display("FAIL reset_test_timeout: only %0d reads seen", tot_reads - r0);
            $fatal(1, "reads stalled");
        end
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        run_one(0, 2, 0, 0, 16'h0000, 1'b0);

        for (int t = 0; t < 4; t++) begin
            foreach (rnd_tab[i]) rnd_tab[i] = $urandom;
            run_one(2, int'($urandom_range(1, 6)), 2, 2, (t == 0) ? 16'hFFF0 : 16'($urandom), 1'b0);
        end

        d3 = dones3;
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        for (int i = 0; i < 500 && dones3 == d3; i++) @(posedge clk);
        if (dones3 == d3) begin
            $display("FAIL k3_timeout: no done from 3x3x3 instance");
            $fatal(1, "k3 run did not complete");
        end
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
